// File: rtl/div11_pkg.sv
// Shared constants, state encoding and operand helpers for the divide-by-11
// reconstruction datapath.
package div11_pkg;

  localparam int DIVISOR = 11;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] R_MAX = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A remainder above DIVISOR-1 can never come out of a real divide.
  function automatic logic r_illegal(input logic [DIGIT_W-1:0] r);
    return (r > R_MAX);
  endfunction

endpackage

// File: rtl/mul11_digit.sv
// One radix-16 digit step of 11*d + cin, split into a result digit and a carry.
// Purely combinational so it can be replicated for an unrolled variant.
module mul11_digit
  import div11_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  input  logic [DIGIT_W-1:0] cin,
  output logic [DIGIT_W-1:0] dout,
  output logic [DIGIT_W-1:0] cout
);

  // 11*15 + 15 = 180 still fits, so illegal carries never wrap.
  logic [2*DIGIT_W-1:0] p_s;

  assign p_s  = (8'(DIVISOR) * {4'd0, d}) + {4'd0, cin};
  assign dout = p_s[DIGIT_W-1:0];
  assign cout = p_s[2*DIGIT_W-1:DIGIT_W];

endmodule

// File: rtl/div11_recon_serial.sv
// Digit-serial rebuild of x = 11*q + r, one radix-16 digit per clock, with
// valid/ready handshakes on both sides.
module div11_recon_serial
  import div11_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q_in,
  input  logic [3:0]     r_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+3:0]   x_out,
  output logic           r_err
);

  localparam int NDIG  = W / DIGIT_W;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  state_t                 state_r;
  logic [W-1:0]           qs_r;
  logic [DIGIT_W-1:0]     carry_r;
  logic [CNT_W-1:0]       cnt_r;
  // Holds all digits but the last; the last one goes straight into x_out.
  logic [W-DIGIT_W-1:0]   acc_r;
  logic [W+3:0]           x_out_r;
  logic                   r_err_r;
  logic                   in_ready_r;
  logic                   out_valid_r;

  logic [DIGIT_W-1:0]     dout_s;
  logic [DIGIT_W-1:0]     cout_s;

  mul11_digit u_digit (
    .d    (qs_r[DIGIT_W-1:0]),
    .cin  (carry_r),
    .dout (dout_s),
    .cout (cout_s)
  );

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      qs_r        <= '0;
      carry_r     <= 4'd0;
      cnt_r       <= '0;
      acc_r       <= '0;
      x_out_r     <= '0;
      r_err_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            qs_r       <= q_in;
            carry_r    <= r_in;
            cnt_r      <= '0;
            acc_r      <= '0;
            r_err_r    <= r_illegal(r_in);
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          qs_r    <= qs_r >> DIGIT_W;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          acc_r   <= {dout_s, acc_r[W-DIGIT_W-1:DIGIT_W]};
          if (cnt_r == LAST_CNT) begin
            x_out_r     <= {cout_s, dout_s, acc_r};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_out     = x_out_r;
  assign r_err     = r_err_r;

endmodule

// File: tb/tb_div11_recon_serial.sv
// Directed plus randomized bench for div11_recon_serial, checked against
// plain 11*q + r arithmetic.
module tb_div11_recon_serial;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   q_in;
  logic [3:0]     r_in;
  logic           out_valid;
  logic           out_ready;
  logic [W+3:0]   x_out;
  logic           r_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  div11_recon_serial #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .r_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .r_err     (r_err)
  );

  function automatic logic [W+3:0] model_x(input logic [W-1:0] q, input logic [3:0] r);
    longint unsigned v;
    v = 64'd11 * 64'(q) + 64'(r);
    return v[W+3:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for out_valid; returns edges seen since the call.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] q, input logic [3:0] r,
                        input logic [W+3:0] exp_x, input logic exp_err);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    q_in     = q;
    r_in     = r;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    wait_out(n);
    check({tag, "_latency"}, 64'(n), 64'(W / 4));
    check({tag, "_x_out"}, 64'(x_out), 64'(exp_x));
    check({tag, "_r_err"}, 64'(r_err), 64'(exp_err));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_after_hs"}, 64'(out_valid), 64'd0);
    check({tag, "_ir_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0]  q;
    logic [W-1:0]  q2;
    logic [3:0]    r;
    logic [3:0]    r2;
    logic [W+3:0]  held;
    int            n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q_in      = '0;
    r_in      = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_x_out", 64'(x_out), 64'd0);
    check("reset_r_err", 64'(r_err), 64'd0);

    // Reset coinciding with in_valid must not accept anything.
    rst      = 1'b1;
    in_valid = 1'b1;
    q_in     = 32'h0000_0001;
    r_in     = 4'd1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_in_ready", 64'(in_ready), 64'd1);
    repeat (12) @(negedge clk);
    check("rst_vs_valid_no_out", 64'(out_valid), 64'd0);

    run_op("zero", 32'h0000_0000, 4'd0, 36'h0_0000_0000, 1'b0);
    run_op("max_carry", 32'hFFFF_FFFF, 4'd10, 36'hA_FFFF_FFFF, 1'b0);
    run_op("pattern", 32'h1234_5678, 4'd3, 36'h0_C83F_B72B, 1'b0);
    run_op("illegal_r", 32'h0000_0005, 4'd12, 36'h0_0000_0043, 1'b1);
    run_op("illegal_max", 32'hFFFF_FFFF, 4'd15, model_x(32'hFFFF_FFFF, 4'd15), 1'b1);

    for (int i = 0; i < 1000; i++) begin
      q = $urandom;
      r = 4'($urandom_range(0, 10));
      run_op("rand_legal", q, r, model_x(q, r), 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      q = $urandom;
      r = 4'($urandom_range(11, 15));
      run_op("rand_illegal", q, r, model_x(q, r), 1'b1);
    end

    // Backpressure: result held while a second operand waits on in_valid.
    q  = $urandom;
    r  = 4'($urandom_range(0, 10));
    q2 = $urandom;
    r2 = 4'($urandom_range(0, 10));
    @(negedge clk);
    in_valid = 1'b1;
    q_in     = q;
    r_in     = r;
    @(posedge clk);
    @(negedge clk);
    q_in = q2;
    r_in = r2;
    wait_out(n);
    check("bp_latency", 64'(n), 64'(W / 4));
    held = x_out;
    check("bp_first_x", 64'(held), 64'(model_x(q, r)));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_x_stable", 64'(x_out), 64'(model_x(q, r)));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", 64'(in_ready), 64'd0);
    wait_out(n);
    check("bp_second_latency", 64'(n), 64'(W / 4));
    check("bp_second_x", 64'(x_out), 64'(model_x(q2, r2)));
    check("bp_second_r_err", 64'(r_err), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while digit 4 is being computed discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    q_in     = 32'hDEAD_BEEF;
    r_in     = 4'd7;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready_after", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_x_out", 64'(x_out), 64'd0);
    check("midrst_r_err", 64'(r_err), 64'd0);
    repeat (12) @(negedge clk);
    check("midrst_no_late_out", 64'(out_valid), 64'd0);
    run_op("after_rst", 32'hCAFE_F00D, 4'd9, model_x(32'hCAFE_F00D, 4'd9), 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
